// File: rtl/gpio_mux_array.sv
// Pad pin-mux array: per-pin function select with break-before-make, input sync/filter and sticky edge IRQs.
// Optional input debounce filter enabled by defining GPIO_MUX_DEBOUNCE_EN.

module gpio_mux_pin #(
    parameter int NUM_FUNCS   = 4,
    parameter int FSEL_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 armed,
    input  logic [FSEL_W-1:0]    sel,
    input  logic                 dir,
    input  logic                 gpio_out,
    input  logic [NUM_FUNCS-1:0] func_out,
    input  logic [NUM_FUNCS-1:0] func_oeb,
    input  logic [1:0]           irq_mode,
    input  logic                 irq_clr,
    input  logic                 in,
    output logic                 gpio_in,
    output logic [NUM_FUNCS-1:0] func_in,
    output logic                 intr,
    output logic                 out,
    output logic                 oeb
);
    localparam logic [FSEL_W:0] NF = (FSEL_W+1)'(NUM_FUNCS);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced, filt, prev, set, in_range;
    logic [FSEL_W-1:0]      sel_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], in};

    assign synced = sync[SYNC_STAGES-1];

`ifdef GPIO_MUX_DEBOUNCE_EN
    localparam int             DBW     = $clog2(DB_CYCLES+1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES-1);

    logic [DBW-1:0] db_cnt;
    logic           filt_q;

    // Count consecutive cycles the synced value disagrees with filt; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            db_cnt <= '0;
            filt_q <= 1'b0;
        end else if (synced == filt_q) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            filt_q <= synced;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end

    assign filt = filt_q;
`else
    assign filt = synced;
`endif

    assign gpio_in  = filt;
    assign in_range = {1'b0, sel_q} < NF;

    always_comb begin
        func_in = '0;
        if (in_range) func_in[sel_q] = filt;
    end

    // A select change parks the pad tristate for one cycle before the new function drives.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sel_q <= '0;
            out   <= 1'b0;
            oeb   <= 1'b1;
        end else if (sel != sel_q) begin
            sel_q <= sel;
            out   <= 1'b0;
            oeb   <= 1'b1;
        end else if (!in_range) begin
            out   <= 1'b0;
            oeb   <= 1'b1;
        end else if (sel_q == '0) begin
            out   <= gpio_out;
            oeb   <= ~dir;
        end else begin
            out   <= func_out[sel_q];
            oeb   <= func_oeb[sel_q];
        end

    assign set = armed & ((filt & ~prev & irq_mode[0]) | (~filt & prev & irq_mode[1]));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            prev <= 1'b0;
            intr <= 1'b0;
        end else begin
            prev <= filt;
            intr <= (intr & ~irq_clr) | set;
        end
endmodule

module gpio_mux_array #(
    parameter int NUM_PINS    = 24,
    parameter int NUM_FUNCS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int FSEL_W      = $clog2(NUM_FUNCS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PINS*FSEL_W-1:0]    sel,
    input  logic [NUM_PINS-1:0]           dir,
    input  logic [NUM_PINS-1:0]           gpio_out,
    output logic [NUM_PINS-1:0]           gpio_in,
    input  logic [NUM_PINS*NUM_FUNCS-1:0] func_out,
    input  logic [NUM_PINS*NUM_FUNCS-1:0] func_oeb,
    output logic [NUM_PINS*NUM_FUNCS-1:0] func_in,
    input  logic [2*NUM_PINS-1:0]         irq_mode,
    input  logic [NUM_PINS-1:0]           irq_clr,
    output logic [NUM_PINS-1:0]           intr,
    output logic                          irq,
    input  logic [NUM_PINS-1:0]           in,
    output logic [NUM_PINS-1:0]           out,
    output logic [NUM_PINS-1:0]           oeb
);
    // Edges are ignored until the input pipeline has flushed its reset contents.
`ifdef GPIO_MUX_DEBOUNCE_EN
    localparam int ARM_MAX = SYNC_STAGES + 1 + DB_CYCLES;
`else
    localparam int ARM_MAX = SYNC_STAGES + 1;
`endif
    localparam int AW = $clog2(ARM_MAX+1);

    logic [AW-1:0] arm_cnt;
    logic          armed;

    assign armed = (arm_cnt == AW'(ARM_MAX));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) irq <= 1'b0;
        else        irq <= |intr;

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        gpio_mux_pin #(
            .NUM_FUNCS  (NUM_FUNCS),
            .FSEL_W     (FSEL_W),
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_pin (
            .clk     (clk),
            .rst_n   (rst_n),
            .armed   (armed),
            .sel     (sel[p*FSEL_W +: FSEL_W]),
            .dir     (dir[p]),
            .gpio_out(gpio_out[p]),
            .func_out(func_out[p*NUM_FUNCS +: NUM_FUNCS]),
            .func_oeb(func_oeb[p*NUM_FUNCS +: NUM_FUNCS]),
            .irq_mode(irq_mode[2*p +: 2]),
            .irq_clr (irq_clr[p]),
            .in      (in[p]),
            .gpio_in (gpio_in[p]),
            .func_in (func_in[p*NUM_FUNCS +: NUM_FUNCS]),
            .intr    (intr[p]),
            .out     (out[p]),
            .oeb     (oeb[p])
        );
    end
endmodule

// File: tb/tb_gpio_mux_array.sv
// Directed bench for gpio_mux_array: mux table vectors plus break-before-make, IRQ and reset sequences.
module tb_gpio_mux_array;
    localparam int NP  = 8;
    localparam int NF  = 3;
    localparam int FW  = 2;
    localparam int SS  = 2;
    localparam int DB  = 16;
`ifdef GPIO_MUX_DEBOUNCE_EN
    localparam int LAT = SS + DB;
`else
    localparam int LAT = SS;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP*FW-1:0] sel;
    logic [NP-1:0]    dir, gpio_out, gpio_in, irq_clr, intr, in, out, oeb;
    logic [NP*NF-1:0] func_out, func_oeb, func_in;
    logic [2*NP-1:0]  irq_mode;
    logic             irq;

    int checks = 0;
    int failures = 0;

    gpio_mux_array #(.NUM_PINS(NP), .NUM_FUNCS(NF), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .dir(dir), .gpio_out(gpio_out), .gpio_in(gpio_in),
        .func_out(func_out), .func_oeb(func_oeb), .func_in(func_in), .irq_mode(irq_mode),
        .irq_clr(irq_clr), .intr(intr), .irq(irq), .in(in), .out(out), .oeb(oeb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int         pin;
        logic [1:0] sel;
        logic       dir, go;
        logic [2:0] fo, fe;
        logic       pin_in;
        logic       eo, eoeb;
        logic [2:0] efin;
    } vec_t;

    vec_t vecs[8];
    logic bad;

    initial begin
        vecs[0] = '{0, 2'd0, 1'b1, 1'b1, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000};
        vecs[1] = '{0, 2'd0, 1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 1'b1, 3'b001};
        vecs[2] = '{1, 2'd1, 1'b0, 1'b0, 3'b010, 3'b101, 1'b1, 1'b1, 1'b0, 3'b010};
        vecs[3] = '{1, 2'd1, 1'b1, 1'b1, 3'b101, 3'b010, 1'b0, 1'b0, 1'b1, 3'b000};
        vecs[4] = '{2, 2'd2, 1'b0, 1'b0, 3'b100, 3'b011, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[5] = '{2, 2'd3, 1'b1, 1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b1, 3'b000};
        vecs[6] = '{7, 2'd2, 1'b1, 1'b1, 3'b011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b100};
        vecs[7] = '{6, 2'd0, 1'b1, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 3'b001};

        // Reset with pads high and rising IRQs enabled
        rst_n = 1'b0; sel = '0; dir = '0; gpio_out = '0; func_out = '0; func_oeb = '0;
        irq_clr = '0; in = '1; irq_mode = {NP{2'b01}};
        #23;
        chk("rst_oeb", 32'(oeb), 32'hFF);
        chk("rst_out", 32'(out), 0);
        chk("rst_intr", 32'(intr), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_gpio_in", 32'(gpio_in), 0);
        chk("rst_func_in", 32'(func_in), 0);
        @(negedge clk) rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (intr != '0 || irq) bad = 1'b1;
        end
        chk("no_spurious_irq", 32'(bad), 0);
        chk("post_rst_gpio_in", 32'(gpio_in), 32'hFF);
        irq_mode = '0;

        // Mux table
        for (int v = 0; v < 8; v++) begin
            sel[vecs[v].pin*FW +: FW]      = vecs[v].sel;
            dir[vecs[v].pin]               = vecs[v].dir;
            gpio_out[vecs[v].pin]          = vecs[v].go;
            func_out[vecs[v].pin*NF +: NF] = vecs[v].fo;
            func_oeb[vecs[v].pin*NF +: NF] = vecs[v].fe;
            in[vecs[v].pin]                = vecs[v].pin_in;
            repeat (LAT + 3) tick();
            chk($sformatf("vec%0d_out", v), 32'(out[vecs[v].pin]), 32'(vecs[v].eo));
            chk($sformatf("vec%0d_oeb", v), 32'(oeb[vecs[v].pin]), 32'(vecs[v].eoeb));
            chk($sformatf("vec%0d_func_in", v), 32'(func_in[vecs[v].pin*NF +: NF]), 32'(vecs[v].efin));
            chk($sformatf("vec%0d_gpio_in", v), 32'(gpio_in[vecs[v].pin]), 32'(vecs[v].pin_in));
        end

        // Pin 3 break-before-make
        dir[3] = 1'b1; gpio_out[3] = 1'b1;
        tick();
        chk("p3_gpio_out", 32'(out[3]), 1);
        chk("p3_gpio_oeb", 32'(oeb[3]), 0);
        sel[3*FW +: FW] = 2'd2; func_out[3*NF+2] = 1'b0; func_oeb[3*NF+2] = 1'b0;
        tick();
        chk("p3_gap_oeb", 32'(oeb[3]), 1);
        chk("p3_gap_out", 32'(out[3]), 0);
        tick();
        chk("p3_f2_oeb", 32'(oeb[3]), 0);
        chk("p3_f2_out", 32'(out[3]), 0);
        sel[3*FW +: FW] = 2'd1; func_out[3*NF+1] = 1'b1; func_oeb[3*NF+1] = 1'b0;
        tick();
        chk("p3_gap2_oeb", 32'(oeb[3]), 1);
        sel[3*FW +: FW] = 2'd2;
        tick();
        chk("p3_regap_oeb", 32'(oeb[3]), 1);
        chk("p3_regap_out", 32'(out[3]), 0);
        tick();
        chk("p3_f2b_oeb", 32'(oeb[3]), 0);
        chk("p3_f2b_func_in", 32'(func_in[3*NF +: NF]), 32'b100);

        // Pin 5 falling-edge IRQ
        irq_mode[11:10] = 2'b10;
        in[5] = 1'b0;
        repeat (LAT) tick();
        chk("p5_filt_fell", 32'(gpio_in[5]), 0);
        chk("p5_intr_pre", 32'(intr[5]), 0);
        tick();
        chk("p5_intr_set", 32'(intr[5]), 1);
        chk("p5_irq_lag", 32'(irq), 0);
        tick();
        chk("p5_irq_set", 32'(irq), 1);
        in[5] = 1'b1;
        repeat (LAT + 2) tick();
        in[5] = 1'b0;
        repeat (LAT) tick();
        irq_clr[5] = 1'b1;
        tick();
        irq_clr[5] = 1'b0;
        chk("p5_set_wins", 32'(intr[5]), 1);
        irq_mode[11:10] = 2'b00;
        repeat (3) tick();
        chk("p5_mode_off_keeps", 32'(intr[5]), 1);
        irq_clr[5] = 1'b1;
        tick();
        irq_clr[5] = 1'b0;
        chk("p5_cleared", 32'(intr[5]), 0);
        chk("p5_irq_still", 32'(irq), 1);
        tick();
        chk("p5_irq_dropped", 32'(irq), 0);

`ifdef GPIO_MUX_DEBOUNCE_EN
        // Pin 4 debounce: short glitch rejected, long pulse accepted
        in[4] = 1'b0;
        repeat (LAT + 3) tick();
        irq_mode[9:8] = 2'b01;
        in[4] = 1'b1;
        repeat (10) tick();
        in[4] = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (gpio_in[4] || intr[4]) bad = 1'b1;
        end
        chk("db_glitch_rejected", 32'(bad), 0);
        in[4] = 1'b1;
        repeat (LAT - 1) tick();
        chk("db_pulse_pre", 32'(gpio_in[4]), 0);
        tick();
        chk("db_pulse_rise", 32'(gpio_in[4]), 1);
        tick();
        chk("db_pulse_intr", 32'(intr[4]), 1);
        irq_mode[9:8] = 2'b00;
`endif

        // Async reset in the middle of a select switch with a flag set
        irq_mode[11:10] = 2'b10;
        in[5] = 1'b1;
        repeat (LAT + 2) tick();
        in[5] = 1'b0;
        repeat (LAT + 1) tick();
        chk("pre_rst_intr", 32'(intr[5]), 1);
        sel[3*FW +: FW] = 2'd0;
        tick();
        chk("pre_rst_gap", 32'(oeb[3]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 32'(out), 0);
        chk("mid_rst_oeb", 32'(oeb), 32'hFF);
        chk("mid_rst_intr", 32'(intr), 0);
        chk("mid_rst_irq", 32'(irq), 0);
        chk("mid_rst_gpio_in", 32'(gpio_in), 0);
        chk("mid_rst_func_in", 32'(func_in), 0);
        #10 rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
